// File: rtl/rvm_ext_unit_if.sv
// EX-stage request/response bundle between the hart and the external RV32M unit.
interface rvm_ext_unit_if #(
  parameter int XLEN = 32
);
  logic            i_EX_en;
  logic [XLEN-1:0] i_EX_rs1;
  logic [XLEN-1:0] i_EX_rs2;
  logic [2:0]      i_EX_f3;
  logic [XLEN-1:0] o_EX_res;
  logic            o_EX_ack;
  logic            o_busy;

  modport master (
    output i_EX_en, i_EX_rs1, i_EX_rs2, i_EX_f3,
    input  o_EX_res, o_EX_ack, o_busy
  );

  modport slave (
    input  i_EX_en, i_EX_rs1, i_EX_rs2, i_EX_f3,
    output o_EX_res, o_EX_ack, o_busy
  );
endinterface

// File: rtl/rvm_ext_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiplier and restoring divider sharing
// one XLEN-step counter; divide-by-zero and signed overflow may complete early.
module rvm_ext_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input logic           i_clk,
  input logic           i_rst,
  rvm_ext_unit_if.slave ex
);
  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            spec_q, spec_d;
  logic [XLEN-1:0] spec_res_q, spec_res_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;

  logic            rs1_signed, rs2_signed;
  logic            rq_s1, rq_s2, rq_div, rq_dz, rq_ovf;
  logic [XLEN-1:0] rq_abs1, rq_abs2, rq_spec_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

  always_comb begin
    rs1_signed = 1'b0;
    rs2_signed = 1'b0;
    case (ex.i_EX_f3)
      3'b001, 3'b100, 3'b110: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b1;
      end
      3'b010: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b0;
      end
      default: begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
      end
    endcase
  end

  assign rq_s1   = rs1_signed & ex.i_EX_rs1[XLEN-1];
  assign rq_s2   = rs2_signed & ex.i_EX_rs2[XLEN-1];
  assign rq_abs1 = rq_s1 ? (ZERO - ex.i_EX_rs1) : ex.i_EX_rs1;
  assign rq_abs2 = rq_s2 ? (ZERO - ex.i_EX_rs2) : ex.i_EX_rs2;
  assign rq_div  = ex.i_EX_f3[2];
  assign rq_dz   = rq_div & (ex.i_EX_rs2 == ZERO);
  assign rq_ovf  = rq_div & ~ex.i_EX_f3[0] & (ex.i_EX_rs1 == SMIN) & (ex.i_EX_rs2 == ONES);
  // f3[1] separates REM/REMU from DIV/DIVU for the special-case results.
  assign rq_spec_res = rq_dz ? (ex.i_EX_f3[1] ? ex.i_EX_rs1 : ONES)
                             : (ex.i_EX_f3[1] ? ZERO : SMIN);

  // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : ZERO)};
  assign div_sh   = {hi_q, lo_q[XLEN-1]};
  assign div_ge   = (div_sh >= {1'b0, a_q});
  assign div_diff = div_sh[XLEN-1:0] - a_q;
  assign step_hi  = f3_q[2] ? (div_ge ? div_diff : div_sh[XLEN-1:0]) : mul_sum[XLEN:1];
  assign step_lo  = f3_q[2] ? {lo_q[XLEN-2:0], div_ge} : {mul_sum[0], lo_q[XLEN-1:1]};

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q ? ({(2*XLEN){1'b0}} - prod) : prod;
  assign quo_fix  = neg_q ? (ZERO - step_lo) : step_lo;
  assign rem_fix  = rneg_q ? (ZERO - step_hi) : step_hi;

  always_comb begin
    fin_res = ZERO;
    case (f3_q)
      3'b000:                 fin_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo_fix;
      3'b110, 3'b111:         fin_res = rem_fix;
      default:                fin_res = ZERO;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    a_d        = a_q;
    f3_d       = f3_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    res_d      = res_q;
    case (state_q)
      IDLE: begin
        if (ex.i_EX_en) begin
          f3_d       = ex.i_EX_f3;
          neg_d      = rq_s1 ^ rq_s2;
          rneg_d     = rq_s1;
          spec_d     = rq_dz | rq_ovf;
          spec_res_d = rq_spec_res;
          hi_d       = ZERO;
          lo_d       = rq_div ? rq_abs1 : rq_abs2;
          a_d        = rq_div ? rq_abs2 : rq_abs1;
          cnt_d      = {CW{1'b0}};
          if ((rq_dz | rq_ovf) && (EARLY_OUT == 1'b1)) begin
            res_d   = rq_spec_res;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!ex.i_EX_en) begin
          state_d = IDLE;
        end else begin
          hi_d = step_hi;
          lo_d = step_lo;
          if (cnt_q == CNT_LAST) begin
            res_d   = spec_q ? spec_res_q : fin_res;
            cnt_d   = {CW{1'b0}};
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = BUSY;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      hi_q       <= ZERO;
      lo_q       <= ZERO;
      a_q        <= ZERO;
      f3_q       <= 3'b000;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= ZERO;
      res_q      <= ZERO;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      a_q        <= a_d;
      f3_q       <= f3_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      res_q      <= res_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  assign ex.o_EX_res = res_q;
  assign ex.o_EX_ack = ack_q;
  assign ex.o_busy   = busy_q;
endmodule
